// File: rtl/down_timer.sv
// down_timer: loadable W-bit down-counter with one-shot and periodic modes.
// The counter counts a reload value R down to zero and emits a one-cycle
// borrow pulse (bo) on the terminal count. In periodic mode the pulses are
// R+1 enabled cycles apart. In one-shot mode the counter parks in DONE.
module down_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         stop,
    input  logic         en,
    input  logic         periodic,
    output logic [W-1:0] cnt,
    output logic         bo,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_ZERO = '0;
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q,   cnt_d;
    logic [W-1:0] reload_q, reload_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    logic         in_run;
    logic         cnt_is_zero;
    logic         ctrl_any;

    assign in_run      = (state_q == S_RUN);
    assign cnt_is_zero = (cnt_q == CNT_ZERO);
    // Any control input pre-empts counting on this cycle, so no borrow.
    assign ctrl_any    = clr | stop | start;

    // Terminal-count pulse, combinational so it lines up with cnt==0.
    assign bo = in_run & en & cnt_is_zero & ~ctrl_any;

    // Next-state logic: clr > stop > start > count; reload updates independently.
    always_comb begin
        // The reload register follows load regardless of the control path;
        // a same-cycle start therefore sees the freshly loaded value.
        reload_d = load ? load_val : reload_q;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (clr) begin
            cnt_d   = CNT_ZERO;
            state_d = S_IDLE;
        end else if (stop && in_run) begin
            // Abort: leave cnt frozen so software can read how far it got.
            state_d = S_IDLE;
        end else if (start) begin
            cnt_d   = reload_d;
            state_d = S_RUN;
        end else if (in_run && en) begin
            if (!cnt_is_zero) begin
                cnt_d = cnt_q - CNT_ONE;
            end else if (periodic) begin
                // Auto-reload from the register as it stood before this
                // cycle's load, so a mid-run load lands on the next reload.
                cnt_d = reload_q;
            end else begin
                // One-shot: cnt stays at 0, never wraps to all-ones.
                state_d = S_DONE;
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, counter, reload and status flops with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each step drives inputs, pushes the
// expected observation to a scoreboard queue, then pops and compares it.
module tb_down_timer;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         en;
    logic         periodic;
    logic [W-1:0] cnt;
    logic         bo;
    logic         busy;
    logic         done;

    int checks;
    int failures;

    typedef struct {
        string        tag;
        logic [W-1:0] cnt;
        logic         bo;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t sb_q[$];

    down_timer #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .periodic (periodic),
        .cnt      (cnt),
        .bo       (bo),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld,
                       input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [W-1:0] x_cnt,
                            input logic x_bo, input logic x_busy, input logic x_done);
        exp_t e;
        e.tag  = tag;
        e.cnt  = x_cnt;
        e.bo   = x_bo;
        e.busy = x_busy;
        e.done = x_done;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, "cnt",  cnt,          e.cnt);
            chk(e.tag, "bo",   W'(bo),       W'(e.bo));
            chk(e.tag, "busy", W'(busy),     W'(e.busy));
            chk(e.tag, "done", W'(done),     W'(e.done));
            $display("step %-10s cnt=%0d bo=%0b busy=%0b done=%0b", e.tag, cnt, bo, busy, done);
        end
    endtask

    // One cycle: drive at negedge, observe 1ns later, then advance a full clock.
    task automatic step(input string tag,
                        input logic c_clr, input logic c_stop, input logic c_start,
                        input logic c_load, input logic [W-1:0] c_lv,
                        input logic c_en, input logic c_per,
                        input logic [W-1:0] x_cnt, input logic x_bo,
                        input logic x_busy, input logic x_done);
        clr = c_clr; stop = c_stop; start = c_start;
        load = c_load; load_val = c_lv; en = c_en; periodic = c_per;
        push_exp(tag, x_cnt, x_bo, x_busy, x_done);
        #1;
        pop_cmp();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plain enabled counting step with no controls.
    task automatic tick(input string tag, input logic c_en, input logic c_per,
                        input logic [W-1:0] x_cnt, input logic x_bo,
                        input logic x_busy, input logic x_done);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, c_en, c_per, x_cnt, x_bo, x_busy, x_done);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        start = 1'b0; stop = 1'b0; en = 1'b0; periodic = 1'b0;

        repeat (2) @(negedge clk);
        push_exp("rst_held", 0, 0, 0, 0);
        #1;
        pop_cmp();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: periodic R=4, en constant
        tick("idle", 0, 0, 0, 0, 0, 0);
        step("t1_arm", 0, 0, 1, 1, 16'd4, 1, 1, 0, 0, 0, 0);
        tick("t1_c4", 1, 1, 4, 0, 1, 0);
        tick("t1_c3", 1, 1, 3, 0, 1, 0);
        tick("t1_c2", 1, 1, 2, 0, 1, 0);
        tick("t1_c1", 1, 1, 1, 0, 1, 0);
        tick("t1_c0", 1, 1, 0, 1, 1, 0);
        tick("t1_r4", 1, 1, 4, 0, 1, 0);
        tick("t1_r3", 1, 1, 3, 0, 1, 0);
        tick("t1_r2", 1, 1, 2, 0, 1, 0);
        tick("t1_r1", 1, 1, 1, 0, 1, 0);
        tick("t1_r0", 1, 1, 0, 1, 1, 0);

        // 2: one-shot R=3 (restart in RUN, start suppresses bo)
        step("t2_arm", 0, 0, 1, 1, 16'd3, 1, 0, 4, 0, 1, 0);
        tick("t2_c3", 1, 0, 3, 0, 1, 0);
        tick("t2_c2", 1, 0, 2, 0, 1, 0);
        tick("t2_c1", 1, 0, 1, 0, 1, 0);
        tick("t2_c0", 1, 0, 0, 1, 1, 0);
        tick("t2_done", 1, 0, 0, 0, 0, 1);
        tick("t2_done2", 1, 1, 0, 0, 0, 1);

        // 3: periodic R=2 with en toggling
        step("t3_arm", 0, 0, 1, 1, 16'd2, 1, 1, 0, 0, 0, 1);
        tick("t3_e1a", 1, 1, 2, 0, 1, 0);
        tick("t3_e0a", 0, 1, 1, 0, 1, 0);
        tick("t3_e1b", 1, 1, 1, 0, 1, 0);
        tick("t3_e0b", 0, 1, 0, 0, 1, 0);
        tick("t3_bo1", 1, 1, 0, 1, 1, 0);
        tick("t3_e0c", 0, 1, 2, 0, 1, 0);
        tick("t3_e1c", 1, 1, 2, 0, 1, 0);
        tick("t3_e0d", 0, 1, 1, 0, 1, 0);
        tick("t3_e1d", 1, 1, 1, 0, 1, 0);
        tick("t3_e0e", 0, 1, 0, 0, 1, 0);
        tick("t3_bo2", 1, 1, 0, 1, 1, 0);

        // 4: R=0 periodic then switch to one-shot
        step("t4_arm", 0, 0, 1, 1, 16'd0, 1, 1, 2, 0, 1, 0);
        tick("t4_bo_a", 1, 1, 0, 1, 1, 0);
        tick("t4_bo_b", 1, 1, 0, 1, 1, 0);
        tick("t4_bo_c", 1, 1, 0, 1, 1, 0);
        tick("t4_last", 1, 0, 0, 1, 1, 0);
        tick("t4_done", 1, 0, 0, 0, 0, 1);

        // 5: priority and boundaries at cnt==0 in RUN
        step("t5_arm", 0, 0, 1, 1, 16'd3, 1, 1, 0, 0, 0, 1);
        tick("t5_c3", 1, 1, 3, 0, 1, 0);
        tick("t5_c2", 1, 1, 2, 0, 1, 0);
        tick("t5_c1", 1, 1, 1, 0, 1, 0);
        step("t5_all3", 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        tick("t5_clred", 1, 1, 0, 0, 0, 0);
        step("t5_rearm", 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        tick("t5_keep3", 1, 1, 3, 0, 1, 0);
        tick("t5_b2", 1, 1, 2, 0, 1, 0);
        tick("t5_b1", 1, 1, 1, 0, 1, 0);
        step("t5_stop0", 0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        tick("t5_stoped", 1, 1, 0, 0, 0, 0);
        step("t5_arm2", 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        tick("t5_d3", 1, 1, 3, 0, 1, 0);
        tick("t5_d2", 1, 1, 2, 0, 1, 0);
        tick("t5_d1", 1, 1, 1, 0, 1, 0);
        step("t5_start0", 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        step("t5_stop3", 0, 1, 0, 0, 0, 1, 1, 3, 0, 1, 0);
        tick("t5_frozen", 1, 1, 3, 0, 0, 0);
        step("t5_stopidl", 0, 1, 0, 0, 0, 1, 1, 3, 0, 0, 0);

        // 6: mid-run reload, then async reset mid-run
        step("t6_arm", 0, 0, 1, 1, 16'd5, 1, 1, 3, 0, 0, 0);
        tick("t6_c5", 1, 1, 5, 0, 1, 0);
        tick("t6_c4", 1, 1, 4, 0, 1, 0);
        tick("t6_c3", 1, 1, 3, 0, 1, 0);
        step("t6_ld1", 0, 0, 0, 1, 16'd1, 1, 1, 2, 0, 1, 0);
        tick("t6_c1", 1, 1, 1, 0, 1, 0);
        tick("t6_c0", 1, 1, 0, 1, 1, 0);
        tick("t6_r1", 1, 1, 1, 0, 1, 0);
        tick("t6_r0", 1, 1, 0, 1, 1, 0);
        tick("t6_s1", 1, 1, 1, 0, 1, 0);
        en = 1'b1; periodic = 1'b1;
        push_exp("t6_async", 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        pop_cmp();
        @(negedge clk);
        rst_n = 1'b1;

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer: the count-down counterpart of the team's modulo up-counter.
- Counts a programmed reload value down to zero and emits a one-cycle borrow pulse (bo) on terminal count, qualified by en.
- Supports one-shot and periodic (auto-reload) modes.
- Used for timeouts, baud/tick generation with runtime-programmable period, and to pace consumers of up-counter carry chains.

Parameters:
W, 16, counter and reload width in bits (W >= 1).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear: cnt<=0, state<=IDLE; reload register kept
load  input  1  capture load_val into reload register
load_val  input  W  reload value R; period = R+1 enabled cycles
start  input  1  arm timer: cnt<=R, state<=RUN
stop  input  1  abort: state<=IDLE, cnt frozen at current value
en  input  1  count enable (tick qualifier), as on the up-counter
periodic  input  1  1 = auto-reload on terminal count, 0 = one-shot
cnt  output  W  current count value
bo  output  1  borrow/terminal pulse (combinational)
busy  output  1  high in RUN
done  output  1  high in DONE (sticky until start/clr/load-start)

Behaviour:
- Reset (rst_n=0, async): cnt=0, reload=0, state=IDLE, busy=0, done=0, bo=0.
- State machine: IDLE, RUN, DONE.
- Control priority per cycle: clr > stop > start > count.
- load is independent of the state update:
  - The reload register takes load_val on any cycle load=1.
  - Same-cycle load+start: start uses the new load_val, i.e. cnt<=load_val.
- clr: cnt<=0, state<=IDLE, done<=0. reload is unchanged.
- stop: only acts in RUN; RUN->IDLE, cnt holds. Ignored in IDLE/DONE.
- start:
  - IDLE or DONE -> RUN, cnt<=R, done<=0.
  - In RUN it restarts: cnt<=R. No bo is generated on that cycle even if cnt==0 and en=1.
- bo = (state==RUN) & en & (cnt==0) & ~clr & ~stop & ~start. bo is combinational and zero-latency relative to cnt, as with co on the up-counter.
- RUN with en=1 and no higher-priority control:
  - cnt>0: cnt<=cnt-1.
  - cnt==0 and periodic=1: cnt<=R (current reload register value); stay RUN.
  - cnt==0 and periodic=0: cnt stays 0, state<=DONE.
- RUN with en=0: hold cnt and state.
- R=0: bo fires on every enabled cycle in periodic mode. In one-shot it fires once, then DONE.
- Period: in periodic mode, consecutive bo pulses are exactly R+1 enabled cycles apart, matching an up-counter with M=R+1.
- periodic is sampled at the terminal-count cycle only; changing it mid-run is legal.
- Loading a new R mid-run does not disturb cnt. It takes effect at the next reload or start.
- busy = (state==RUN); done = (state==DONE). Both are registered.
- Arithmetic: unsigned W-bit. No underflow past 0 is possible; the 0 -> all-ones wrap must never occur.
- Async reset mid-run returns everything to reset values immediately; no bo on the reset edge.

Test Plan:
1. Reset, then load=1 load_val=4, start, en=1 constant, periodic=1 -> cnt sequence 4,3,2,1,0,4,3...; bo high exactly when cnt==0, every 5 cycles; busy=1 throughout.
2. One-shot, R=3, en=1 -> cnt 3,2,1,0; single bo on the cnt==0 cycle; next cycle done=1, busy=0, cnt=0; further en produces no bo.
3. Periodic R=2, en toggling 1,0,1,0... -> cnt decrements only on en=1 cycles; bo pulses 3 enabled cycles apart; cnt holds on en=0 cycles.
4. R=0 periodic, en=1 -> bo=1 every cycle, cnt=0. Then set periodic=0 -> next cycle DONE, bo=0 afterwards.
5. Priority and boundaries, in a RUN at cnt=0 with en=1:
   - clr+stop+start all asserted -> clr wins: cnt=0, IDLE, no bo.
   - Separately, stop -> IDLE, cnt frozen, no bo.
   - start at cnt==0 -> cnt<=R, no bo.
6. Mid-run reload: R=5 running at cnt=2, load_val=1 -> cnt continues 1,0; then reloads to 1; period changes to 2 cycles. Assert rst_n=0 mid-run -> cnt=0, busy=0, done=0 immediately (before the next clock edge).
